// File: rtl/mc_maindec.sv
`default_nettype none
// ============================================================================
// Module      : mc_maindec
// Description : Main decoder / control FSM of a multicycle MIPS-style core.
//               Moore machine walking each instruction through FETCH, DECODE
//               and its execute/writeback states; control outputs are
//               registered (loaded from the state being entered) so they
//               depend only on the current state. pcen is the only output
//               combining state with the live ALU zero flag. instret counts
//               retired instructions and wraps silently.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset
//               op       - opcode field instr[31:26]
//               zero     - ALU zero flag of the current cycle
//               aluop    - 00 add, 01 subtract, 10 decode funct
//               alusrca, alusrcb, pcsrc, iord, regdst, memtoreg - mux selects
//               irwrite, memwrite, regwrite, pcen - write enables
//               state    - current FSM state (debug)
//               instret  - retired instruction count
// Config      : define MC_MAINDEC_BNE_EN to add bne (op 000101, state 12)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_maindec (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic        zero,
    output logic [1:0]  aluop,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic        iord,
    output logic        regdst,
    output logic        memtoreg,
    output logic        irwrite,
    output logic        memwrite,
    output logic        regwrite,
    output logic        pcen,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;
`ifdef MC_MAINDEC_BNE_EN
    localparam logic [5:0] c_op_bne   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`ifdef MC_MAINDEC_BNE_EN
        , BNEEX = 4'd12
`endif
    } state_t;

    // Full control word held per state. branchn marks an inverted-sense
    // branch (bne); it stays 0 when that instruction is not built in.
    typedef struct packed {
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       pcwrite;
        logic       branch;
        logic       branchn;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alusrcb = 2'b01;
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
            end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB:  c.regwrite = 1'b1;
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
`ifdef MC_MAINDEC_BNE_EN
            BNEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branchn = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_of(input state_t s, input logic [5:0] opc);
        state_t n;
        n = FETCH;
        case (s)
            FETCH:   n = DECODE;
            DECODE: begin
                case (opc)
                    c_op_lw, c_op_sw: n = MEMADR;
                    c_op_rtype:       n = RTYPEEX;
                    c_op_beq:         n = BEQEX;
                    c_op_addi:        n = ADDIEX;
                    c_op_j:           n = JEX;
`ifdef MC_MAINDEC_BNE_EN
                    c_op_bne:         n = BNEEX;
`endif
                    default:          n = FETCH; // unknown opcode: drop it
                endcase
            end
            MEMADR:  n = (opc == c_op_lw) ? MEMRD : MEMWR;
            MEMRD:   n = MEMWB;
            RTYPEEX: n = RTYPEWB;
            ADDIEX:  n = ADDIWB;
            default: n = FETCH;
        endcase
        return n;
    endfunction

    // States whose exit completes an instruction.
    function automatic logic retires(input state_t s);
        logic r;
        case (s)
            MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX: r = 1'b1;
`ifdef MC_MAINDEC_BNE_EN
            BNEEX:                                     r = 1'b1;
`endif
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

    state_t      r_state;
    ctrl_t       r_ctrl;
    logic [31:0] r_instret;
    state_t      w_next;

    assign w_next = next_of(r_state, op);

    // Control word is loaded with the decode of the state being entered,
    // so it always matches r_state without a decode stage on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH;
            r_ctrl    <= ctrl_of(FETCH);
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_of(w_next);
            if (retires(r_state)) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign aluop    = r_ctrl.aluop;
    assign alusrca  = r_ctrl.alusrca;
    assign alusrcb  = r_ctrl.alusrcb;
    assign pcsrc    = r_ctrl.pcsrc;
    assign iord     = r_ctrl.iord;
    assign regdst   = r_ctrl.regdst;
    assign memtoreg = r_ctrl.memtoreg;

    // Write enables are squashed while reset is held, independent of state.
    assign irwrite  = r_ctrl.irwrite  & ~rst;
    assign memwrite = r_ctrl.memwrite & ~rst;
    assign regwrite = r_ctrl.regwrite & ~rst;
    assign pcen     = ~rst & (r_ctrl.pcwrite
                              | (r_ctrl.branch  &  zero)
                              | (r_ctrl.branchn & ~zero));

    assign state    = r_state;
    assign instret  = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mc_maindec.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_maindec
// Description : Directed self-checking bench for mc_maindec. Inputs change and
//               outputs are sampled 1 time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_maindec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op = 6'd0;
    logic        zero = 1'b0;
    logic [1:0]  aluop;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  pcsrc;
    logic        iord;
    logic        regdst;
    logic        memtoreg;
    logic        irwrite;
    logic        memwrite;
    logic        regwrite;
    logic        pcen;
    logic [3:0]  state;
    logic [31:0] instret;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ir   = 32'd0;

    mc_maindec dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .zero     (zero),
        .aluop    (aluop),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .iord     (iord),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .irwrite  (irwrite),
        .memwrite (memwrite),
        .regwrite (regwrite),
        .pcen     (pcen),
        .state    (state),
        .instret  (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (state !== 4'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++; if (instret !== 32'd0) begin n_errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
        n_checks++; if ({irwrite, memwrite, regwrite, pcen} !== 4'b0000) begin n_errors++; $display("FAIL reset_enables_forced: got %b expected 0000", {irwrite, memwrite, regwrite, pcen}); end
        rst = 1'b0;
        #1;
        n_checks++; if ({irwrite, pcen} !== 2'b11) begin n_errors++; $display("FAIL fetch_enables: got %b expected 11", {irwrite, pcen}); end
        n_checks++; if ({iord, alusrca, alusrcb, aluop, pcsrc} !== 8'b0_0_01_00_00) begin n_errors++; $display("FAIL fetch_selects: got %b expected 00010000", {iord, alusrca, alusrcb, aluop, pcsrc}); end
    endtask

    task automatic test_lw();
        int seq[6];
        seq = '{0, 1, 2, 3, 4, 0};
        op = 6'b100011;
        zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            n_checks++; if (state !== 4'(seq[i])) begin n_errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, seq[i]); end
            n_checks++; if (regwrite !== 1'(seq[i] == 4)) begin n_errors++; $display("FAIL lw_regwrite[%0d]: got %b expected %b", i, regwrite, seq[i] == 4); end
            if (seq[i] == 1) begin
                n_checks++; if (alusrcb !== 2'b11) begin n_errors++; $display("FAIL decode_alusrcb: got %b expected 11", alusrcb); end
            end
            if (seq[i] == 2) begin
                n_checks++; if ({alusrca, alusrcb} !== 3'b110) begin n_errors++; $display("FAIL memadr_src: got %b expected 110", {alusrca, alusrcb}); end
            end
            if (seq[i] == 3) begin
                n_checks++; if (iord !== 1'b1) begin n_errors++; $display("FAIL memrd_iord: got %b expected 1", iord); end
            end
            if (seq[i] == 4) begin
                n_checks++; if ({regdst, memtoreg} !== 2'b01) begin n_errors++; $display("FAIL memwb_sel: got %b expected 01", {regdst, memtoreg}); end
            end
        end
        exp_ir = exp_ir + 32'd1;
        n_checks++; if (instret !== exp_ir) begin n_errors++; $display("FAIL lw_instret: got %0d expected %0d", instret, exp_ir); end
    endtask

    task automatic test_sw_add();
        int seq[9];
        seq = '{0, 1, 2, 5, 0, 1, 6, 7, 0};
        op = 6'b101011;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            if (i == 4) op = 6'b000000;
            n_checks++; if (state !== 4'(seq[i])) begin n_errors++; $display("FAIL swadd_state[%0d]: got %0d expected %0d", i, state, seq[i]); end
            n_checks++; if (memwrite !== 1'(seq[i] == 5)) begin n_errors++; $display("FAIL swadd_memwrite[%0d]: got %b expected %b", i, memwrite, seq[i] == 5); end
            n_checks++; if ((aluop == 2'b10) !== (seq[i] == 6)) begin n_errors++; $display("FAIL swadd_aluop[%0d]: got %b in state %0d", i, aluop, seq[i]); end
            if (seq[i] == 7) begin
                n_checks++; if ({regdst, memtoreg, regwrite} !== 3'b101) begin n_errors++; $display("FAIL rtypewb_sel: got %b expected 101", {regdst, memtoreg, regwrite}); end
            end
        end
        exp_ir = exp_ir + 32'd2;
        n_checks++; if (instret !== exp_ir) begin n_errors++; $display("FAIL swadd_instret: got %0d expected %0d", instret, exp_ir); end
    endtask

    task automatic test_addi();
        int seq[5];
        seq = '{0, 1, 9, 10, 0};
        op = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_checks++; if (state !== 4'(seq[i])) begin n_errors++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state, seq[i]); end
            if (seq[i] == 9) begin
                n_checks++; if ({alusrca, alusrcb, aluop} !== 5'b11000) begin n_errors++; $display("FAIL addiex_sel: got %b expected 11000", {alusrca, alusrcb, aluop}); end
            end
            if (seq[i] == 10) begin
                n_checks++; if ({regdst, memtoreg, regwrite} !== 3'b001) begin n_errors++; $display("FAIL addiwb_sel: got %b expected 001", {regdst, memtoreg, regwrite}); end
            end
        end
        exp_ir = exp_ir + 32'd1;
        n_checks++; if (instret !== exp_ir) begin n_errors++; $display("FAIL addi_instret: got %0d expected %0d", instret, exp_ir); end
    endtask

    task automatic test_beq();
        for (int k = 0; k < 2; k++) begin
            op = 6'b000100;
            zero = (k == 0);
            tick();
            tick();
            n_checks++; if (state !== 4'd8) begin n_errors++; $display("FAIL beq_state[%0d]: got %0d expected 8", k, state); end
            n_checks++; if (pcen !== zero) begin n_errors++; $display("FAIL beq_pcen[%0d]: got %b expected %b", k, pcen, zero); end
            n_checks++; if ({pcsrc, aluop, alusrca, alusrcb} !== 7'b01_01_1_00) begin n_errors++; $display("FAIL beq_sel[%0d]: got %b expected 0101100", k, {pcsrc, aluop, alusrca, alusrcb}); end
            tick();
            exp_ir = exp_ir + 32'd1;
            n_checks++; if (state !== 4'd0) begin n_errors++; $display("FAIL beq_return[%0d]: got %0d expected 0", k, state); end
            n_checks++; if (instret !== exp_ir) begin n_errors++; $display("FAIL beq_instret[%0d]: got %0d expected %0d", k, instret, exp_ir); end
        end
        zero = 1'b0;
    endtask

    task automatic test_unknown_j();
        op = 6'b111111;
        tick();
        n_checks++; if (state !== 4'd1) begin n_errors++; $display("FAIL unk_decode: got %0d expected 1", state); end
        tick();
        n_checks++; if (state !== 4'd0) begin n_errors++; $display("FAIL unk_fetch: got %0d expected 0", state); end
        n_checks++; if (instret !== exp_ir) begin n_errors++; $display("FAIL unk_instret: got %0d expected %0d", instret, exp_ir); end
        op = 6'b000010;
        tick();
        tick();
        n_checks++; if (state !== 4'd11) begin n_errors++; $display("FAIL j_state: got %0d expected 11", state); end
        n_checks++; if ({pcen, pcsrc} !== 3'b110) begin n_errors++; $display("FAIL j_pc: got %b expected 110", {pcen, pcsrc}); end
        tick();
        exp_ir = exp_ir + 32'd1;
        n_checks++; if ({state, instret} !== {4'd0, exp_ir}) begin n_errors++; $display("FAIL j_retire: got %0d/%0d expected 0/%0d", state, instret, exp_ir); end
    endtask

    task automatic test_bne();
        op = 6'b000101;
`ifdef MC_MAINDEC_BNE_EN
        for (int k = 0; k < 2; k++) begin
            zero = (k == 1);
            tick();
            tick();
            n_checks++; if (state !== 4'd12) begin n_errors++; $display("FAIL bne_state[%0d]: got %0d expected 12", k, state); end
            n_checks++; if (pcen !== ~zero) begin n_errors++; $display("FAIL bne_pcen[%0d]: got %b expected %b", k, pcen, ~zero); end
            n_checks++; if ({pcsrc, aluop} !== 4'b0101) begin n_errors++; $display("FAIL bne_sel[%0d]: got %b expected 0101", k, {pcsrc, aluop}); end
            tick();
            exp_ir = exp_ir + 32'd1;
            n_checks++; if (instret !== exp_ir) begin n_errors++; $display("FAIL bne_instret[%0d]: got %0d expected %0d", k, instret, exp_ir); end
        end
        zero = 1'b0;
`else
        tick();
        tick();
        n_checks++; if (state !== 4'd0) begin n_errors++; $display("FAIL bne_unknown_state: got %0d expected 0", state); end
        n_checks++; if (instret !== exp_ir) begin n_errors++; $display("FAIL bne_unknown_instret: got %0d expected %0d", instret, exp_ir); end
`endif
    endtask

    task automatic test_reset_mid();
        op = 6'b100011;
        tick();
        tick();
        tick();
        n_checks++; if (state !== 4'd3) begin n_errors++; $display("FAIL mid_reach3: got %0d expected 3", state); end
        rst = 1'b1;
        #1;
        n_checks++; if ({irwrite, memwrite, regwrite, pcen} !== 4'b0000) begin n_errors++; $display("FAIL mid_forced: got %b expected 0000", {irwrite, memwrite, regwrite, pcen}); end
        tick();
        exp_ir = 32'd0;
        n_checks++; if (state !== 4'd0) begin n_errors++; $display("FAIL mid_state: got %0d expected 0", state); end
        n_checks++; if (instret !== exp_ir) begin n_errors++; $display("FAIL mid_instret: got %0d expected 0", instret); end
        n_checks++; if (regwrite !== 1'b0) begin n_errors++; $display("FAIL mid_regwrite: got %b expected 0", regwrite); end
        rst = 1'b0;
        tick();
        n_checks++; if (state !== 4'd1) begin n_errors++; $display("FAIL mid_restart: got %0d expected 1", state); end
        tick();
        tick();
        tick();
        n_checks++; if ({state, regwrite} !== {4'd4, 1'b1}) begin n_errors++; $display("FAIL mid_lw_wb: got %0d/%b expected 4/1", state, regwrite); end
        tick();
        exp_ir = exp_ir + 32'd1;
        n_checks++; if (instret !== exp_ir) begin n_errors++; $display("FAIL mid_lw_instret: got %0d expected %0d", instret, exp_ir); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_add();
        test_addi();
        test_beq();
        test_unknown_j();
        test_bne();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
